rx_chain_mc: RTL and testbench

RX_CHAIN_MC -- requirements
Module: rx_chain_mc

---
 rtl/rx_chain_mc.sv | 185 ++++++++++++++++++
 tb/tb_rx_chain_mc.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_chain_mc.sv
// Multichannel receive chain: per-channel I/Q decimating accumulators feeding a frame serializer.
// Optional feature macro RX_MC_ROUND_EN: round half up before the scaling shift.
module rx_chain_mc #(
  parameter int NCH     = 2,
  parameter int WIDTH   = 16,
  parameter int CFGADDR = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [6:0]             serial_addr,
  input  logic [31:0]            serial_data,
  input  logic                   serial_strobe,
  input  logic                   sample_strobe,
  input  logic [NCH*WIDTH-1:0]   i_in,
  input  logic [NCH*WIDTH-1:0]   q_in,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [1:0]             out_chan,
  output logic [15:0]            overrun_count,
  output logic                   dbg_state
);

  localparam int AW = WIDTH + 8;
  localparam int RW = AW + 32;
  localparam int NW = 2 * NCH;
  localparam int IW = $clog2(NW);
  localparam logic signed [RW-1:0] MAXV = RW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] MINV = -MAXV - RW'(1);

  // Output handshake: a word transfers on a rising edge where out_valid && out_ready;
  // out_data/out_last/out_chan stay stable while out_valid is high and out_ready is low.
  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              rate_q, rate_d;
  logic [4:0]              shift_q, shift_d;
  logic [7:0]              cnt_q, cnt_d;
  logic signed [AW-1:0]    ai_q [NCH];
  logic signed [AW-1:0]    ai_d [NCH];
  logic signed [AW-1:0]    aq_q [NCH];
  logic signed [AW-1:0]    aq_d [NCH];
  logic [WIDTH-1:0]        frame_q [NW];
  logic [WIDTH-1:0]        frame_d [NW];
  logic [IW-1:0]           idx_q, idx_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [1:0]              out_chan_q, out_chan_d;
  logic [15:0]             ovr_q, ovr_d;

  logic                    cfg_wr, done, hs, accept;
  logic [7:0]              dec;
  logic [IW-1:0]           nxt;
  logic signed [AW-1:0]    sum_i [NCH];
  logic signed [AW-1:0]    sum_q [NCH];
  logic [WIDTH-1:0]        new_w [NW];

  function automatic logic [WIDTH-1:0] scale(input logic signed [AW-1:0] s,
                                             input logic [4:0] sh);
    logic signed [RW-1:0] t;
    logic signed [RW-1:0] r;
    t = {{(RW-AW){s[AW-1]}}, s};
`ifdef RX_MC_ROUND_EN
    if (sh != 5'd0) t = t + (RW'(1) << (sh - 5'd1));
`endif
    r = t >>> sh;
    if (r > MAXV)      scale = MAXV[WIDTH-1:0];
    else if (r < MINV) scale = MINV[WIDTH-1:0];
    else               scale = r[WIDTH-1:0];
  endfunction

  always_comb begin
    cfg_wr = serial_strobe && (serial_addr == 7'(CFGADDR));
    dec    = (rate_q == 8'd0) ? 8'd1 : rate_q;
    done   = enable && sample_strobe && !cfg_wr && ((cnt_q + 8'd1) == dec);
    for (int k = 0; k < NCH; k++) begin
      sum_i[k] = ai_q[k] + {{8{i_in[k*WIDTH+WIDTH-1]}}, i_in[k*WIDTH +: WIDTH]};
      sum_q[k] = aq_q[k] + {{8{q_in[k*WIDTH+WIDTH-1]}}, q_in[k*WIDTH +: WIDTH]};
      new_w[2*k]   = scale(sum_i[k], shift_q);
      new_w[2*k+1] = scale(sum_q[k], shift_q);
    end

    rate_d  = rate_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    ai_d    = ai_q;
    aq_d    = aq_q;
    if (cfg_wr) begin
      rate_d  = serial_data[7:0];
      shift_d = serial_data[12:8];
    end
    // Config writes and a disabled chain both park the decimator at zero.
    if (cfg_wr || !enable || done) begin
      cnt_d = 8'd0;
      for (int k = 0; k < NCH; k++) begin
        ai_d[k] = '0;
        aq_d[k] = '0;
      end
    end else if (sample_strobe) begin
      cnt_d = cnt_q + 8'd1;
      ai_d  = sum_i;
      aq_d  = sum_q;
    end

    hs          = out_valid_q && out_ready;
    accept      = done && ((state_q == S_IDLE) || (hs && out_last_q));
    nxt         = idx_q + 1'b1;
    state_d     = state_q;
    frame_d     = frame_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_chan_d  = out_chan_q;
    if (accept) begin
      state_d     = S_SEND;
      frame_d     = new_w;
      idx_d       = '0;
      out_data_d  = new_w[0];
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
      out_chan_d  = 2'd0;
    end else if (hs) begin
      if (out_last_q) begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end else begin
        idx_d      = nxt;
        out_data_d = frame_q[nxt];
        out_last_d = (nxt == IW'(NW - 1));
        out_chan_d = 2'(32'(nxt) >> 1);
      end
    end

    ovr_d = ovr_q;
    if (done && !accept && (ovr_q != 16'hFFFF)) ovr_d = ovr_q + 16'd1;
    if (cfg_wr && serial_data[31]) ovr_d = 16'd0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rate_q      <= 8'd4;
      shift_q     <= 5'd2;
      cnt_q       <= 8'd0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_chan_q  <= 2'd0;
      ovr_q       <= 16'd0;
      for (int k = 0; k < NCH; k++) begin
        ai_q[k] <= '0;
        aq_q[k] <= '0;
      end
      for (int w = 0; w < NW; w++) frame_q[w] <= '0;
    end else begin
      state_q     <= state_d;
      rate_q      <= rate_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_chan_q  <= out_chan_d;
      ovr_q       <= ovr_d;
      ai_q        <= ai_d;
      aq_q        <= aq_d;
      frame_q     <= frame_d;
    end
  end

  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign out_chan      = out_chan_q;
  assign overrun_count = ovr_q;
  assign dbg_state     = (state_q == S_SEND);

endmodule

// File: tb/tb_rx_chain_mc.sv
// Bench for rx_chain_mc: directed scenarios plus random traffic against a frame-level reference model.
module tb_rx_chain_mc;

  localparam int NCH     = 2;
  localparam int WIDTH   = 16;
  localparam int CFGADDR = 5;
  localparam int NW      = 2 * NCH;
  localparam int W       = WIDTH + 3;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 enable;
  logic [6:0]           serial_addr;
  logic [31:0]          serial_data;
  logic                 serial_strobe;
  logic                 sample_strobe;
  logic [NCH*WIDTH-1:0] i_in, q_in;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid, out_ready, out_last;
  logic [1:0]           out_chan;
  logic [15:0]          overrun_count;
  logic                 dbg_state;

  rx_chain_mc #(.NCH(NCH), .WIDTH(WIDTH), .CFGADDR(CFGADDR)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .serial_addr(serial_addr), .serial_data(serial_data), .serial_strobe(serial_strobe),
    .sample_strobe(sample_strobe), .i_in(i_in), .q_in(q_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_chan(out_chan), .overrun_count(overrun_count),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  function automatic void chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: integer sums per channel, a strobe count and a count of words still to send.
  int m_rate, m_shift, m_cnt, m_pending, m_ovr;
  longint m_si[NCH], m_sq[NCH];

  function automatic int scale_m(longint sum, int sh);
    longint t;
    t = sum;
`ifdef RX_MC_ROUND_EN
    if (sh > 0) t = t + (longint'(1) <<< (sh - 1));
`endif
    t = t >>> sh;
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    return int'(t);
  endfunction

  task automatic m_clear();
    m_cnt = 0;
    for (int k = 0; k < NCH; k++) begin
      m_si[k] = 0;
      m_sq[k] = 0;
    end
  endtask

  always @(negedge clock) begin
    bit done;
    int d;
    logic [W-1:0] words[NW];
    if (!reset) begin
      m_rate = 4; m_shift = 2; m_pending = 0; m_ovr = 0;
      m_clear();
      exp_q.delete();
    end else begin
      chk("valid", out_valid, m_pending > 0);
      chk("overrun", overrun_count, m_ovr);
      if (m_pending > 0 && out_ready) m_pending--;
      done = 0;
      if (serial_strobe && serial_addr == 7'(CFGADDR)) begin
        m_rate  = serial_data[7:0];
        m_shift = serial_data[12:8];
        if (serial_data[31]) m_ovr = 0;
        m_clear();
      end else if (!enable) begin
        m_clear();
      end else if (sample_strobe) begin
        for (int k = 0; k < NCH; k++) begin
          m_si[k] += longint'($signed(i_in[k*WIDTH +: WIDTH]));
          m_sq[k] += longint'($signed(q_in[k*WIDTH +: WIDTH]));
        end
        m_cnt++;
        d = (m_rate == 0) ? 1 : m_rate;
        if (m_cnt == d) begin
          done = 1;
          for (int k = 0; k < NCH; k++) begin
            words[2*k]   = {2'(k), 1'b0, 16'(scale_m(m_si[k], m_shift))};
            words[2*k+1] = {2'(k), (k == NCH - 1), 16'(scale_m(m_sq[k], m_shift))};
          end
          m_clear();
        end
      end
      if (done) begin
        if (m_pending == 0) begin
          for (int w = 0; w < NW; w++) exp_q.push_back(words[w]);
          m_pending = NW;
        end else if (m_ovr < 65535) begin
          m_ovr++;
        end
      end
    end
  end

  // Monitor: every handshake about to happen on the next rising edge pops one expected word.
  always @(negedge clock) begin
    logic [W-1:0] e;
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", longint'($signed(out_data)), longint'($signed(e[15:0])));
        chk("word_last", out_last, e[16]);
        chk("word_chan", out_chan, e[18:17]);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic cfg_write(input logic [6:0] a, input logic [31:0] d);
    serial_addr   = a;
    serial_data   = d;
    serial_strobe = 1'b1;
    sample_strobe = 1'b0;
    tick();
    serial_strobe = 1'b0;
  endtask

  task automatic set_all(input int iv, input int qv);
    for (int k = 0; k < NCH; k++) begin
      i_in[k*WIDTH +: WIDTH] = 16'(iv);
      q_in[k*WIDTH +: WIDTH] = 16'(qv);
    end
  endtask

  task automatic strobes(input int n);
    sample_strobe = 1'b1;
    repeat (n) tick();
    sample_strobe = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_chan"}, out_chan, 0);
    chk({tag, "_overrun"}, overrun_count, 0);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; serial_addr = '0; serial_data = '0;
    serial_strobe = 1'b0; sample_strobe = 1'b0; i_in = '0; q_in = '0; out_ready = 1'b1;
    tick(); tick();
    check_idle_outputs("reset");
    reset = 1'b1;
    tick();

    // Defaults: R=4, S=2, constant samples.
    enable = 1'b1;
    set_all(100, -100);
    strobes(40);
    repeat (8) tick();

    // Pass-through and full-scale saturation in both directions.
    cfg_write(7'(CFGADDR), 32'h0000_0001);
    set_all(32767, -32768);
    strobes(1);
    repeat (6) tick();
    cfg_write(7'(CFGADDR), 32'h0000_00FF);
    strobes(255);
    repeat (6) tick();

    // Back-pressure: one frame held, four dropped, then cleared.
    cfg_write(7'(CFGADDR), 32'h8000_0002);
    set_all(1234, -4321);
    out_ready = 1'b0;
    strobes(10);
    chk("overrun_four", overrun_count, 4);
    out_ready = 1'b1;
    repeat (6) tick();
    cfg_write(7'(CFGADDR), 32'h8000_0002);
    chk("overrun_cleared", overrun_count, 0);

    // Rounding case: sum 3, shift 1.
    cfg_write(7'(CFGADDR), 32'h0000_0101);
    set_all(3, -3);
    strobes(1);
    repeat (6) tick();

    // Back-to-back frames landing exactly on the last-word handshake.
    cfg_write(7'(CFGADDR), 32'h0000_0004);
    set_all(-777, 555);
    strobes(24);
    chk("b2b_no_overrun", overrun_count, 0);
    repeat (6) tick();

    // Random traffic with occasional (sometimes misaddressed) config writes.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        cfg_write(($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : 7'(CFGADDR),
                  {($urandom_range(0, 3) == 0), 18'd0, 5'($urandom_range(0, 6)),
                   8'($urandom_range(0, 5))});
      end
      enable        = ($urandom_range(0, 9) != 0);
      sample_strobe = ($urandom_range(0, 9) < 7);
      out_ready     = ($urandom_range(0, 9) < 6);
      i_in          = NCH*WIDTH'($urandom);
      q_in          = NCH*WIDTH'($urandom);
      tick();
    end
    sample_strobe = 1'b0;
    out_ready = 1'b1;
    enable = 1'b1;
    repeat (10) tick();

    // Reset in the middle of a frame, then a fresh frame with reset-default config.
    cfg_write(7'(CFGADDR), 32'h8000_0204);
    set_all(100, -100);
    out_ready = 1'b0;
    strobes(4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    reset = 1'b0;
    #1;
    check_idle_outputs("midframe_reset");
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    strobes(3);
    chk("not_yet_valid", out_valid, 0);
    strobes(1);
    chk("first_word_latency", out_valid, 1);
    chk("first_word_data", longint'($signed(out_data)), 100);
    repeat (10) tick();

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
